gb_debug: RTL and testbench

Halt-time debug monitor for the Game Boy core. While the CPU `halt` input is high, it snapshots the bus, CPU and PPU status signals on a Game Boy clock edge. It formats the snapshot as one fixed-length line of uppercase ASCII hex and transmits it on a UART TX pin (8N1). It sits beside the core, drives only the host-facing serial line, and never influences core state.

---
 rtl/gb_debug.sv | 154 +++++++++++++++
 tb/tb_gb_debug.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/gb_debug.sv
// rtl/gb_debug.sv - halt-time debug monitor: snapshots bus/CPU/PPU state on a gb clock edge
// and sends it as one 67-char uppercase-hex ASCII line over an 8N1 UART.
module gb_debug #(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        gb_clk,
  input  logic        halt,
  input  logic [15:0] addr,
  input  logic [7:0]  data,
  input  logic        rd,
  input  logic        wr,
  input  logic        cs,
  input  logic [7:0]  opcode,
  input  logic [15:0] pc,
  input  logic [15:0] last_pc,
  input  logic [7:0]  lcdc,
  input  logic [7:0]  stat,
  input  logic [4:0]  ppu_state,
  output logic        tx
);
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CLK_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_SEND = 1'b1;

  logic          halt_s1, halt_s2, gb_s1, gb_s2, gb_prev;
  logic          gb_edge;
  logic [0:0]    state;
  logic [6:0]    char_idx;
  logic [3:0]    bit_idx;
  logic [CW-1:0] clk_cnt;
  logic [7:0]    cur_char;

  logic [15:0] sh_addr, sh_pc, sh_last_pc;
  logic [7:0]  sh_data, sh_opcode, sh_lcdc, sh_stat;
  logic        sh_rd, sh_wr, sh_cs;
  logic [4:0]  sh_ppu;

  assign gb_edge = gb_s2 & ~gb_prev;

  function automatic logic [7:0] hex(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  // Character generator: fixed template, fields read from the shadow snapshot.
  always_comb begin
    cur_char = 8'h0A;
    case (char_idx)
      7'd0, 7'd53:                                     cur_char = "A";
      7'd1, 7'd8, 7'd15, 7'd22, 7'd28, 7'd37, 7'd47, 7'd55, 7'd62:
                                                       cur_char = "=";
      7'd6, 7'd11, 7'd19, 7'd25, 7'd33, 7'd42, 7'd50, 7'd58:
                                                       cur_char = " ";
      7'd7, 7'd45:                                     cur_char = "D";
      7'd12:                                           cur_char = "R";
      7'd13:                                           cur_char = "W";
      7'd14, 7'd27, 7'd36, 7'd44, 7'd46:               cur_char = "C";
      7'd20:                                           cur_char = "O";
      7'd21, 7'd26, 7'd35, 7'd59, 7'd60:               cur_char = "P";
      7'd34, 7'd43:                                    cur_char = "L";
      7'd51:                                           cur_char = "S";
      7'd52, 7'd54:                                    cur_char = "T";
      7'd61:                                           cur_char = "U";
      7'd2:  cur_char = hex(sh_addr[15:12]);
      7'd3:  cur_char = hex(sh_addr[11:8]);
      7'd4:  cur_char = hex(sh_addr[7:4]);
      7'd5:  cur_char = hex(sh_addr[3:0]);
      7'd9:  cur_char = hex(sh_data[7:4]);
      7'd10: cur_char = hex(sh_data[3:0]);
      7'd16: cur_char = {7'b0011000, sh_rd};
      7'd17: cur_char = {7'b0011000, sh_wr};
      7'd18: cur_char = {7'b0011000, sh_cs};
      7'd23: cur_char = hex(sh_opcode[7:4]);
      7'd24: cur_char = hex(sh_opcode[3:0]);
      7'd29: cur_char = hex(sh_pc[15:12]);
      7'd30: cur_char = hex(sh_pc[11:8]);
      7'd31: cur_char = hex(sh_pc[7:4]);
      7'd32: cur_char = hex(sh_pc[3:0]);
      7'd38: cur_char = hex(sh_last_pc[15:12]);
      7'd39: cur_char = hex(sh_last_pc[11:8]);
      7'd40: cur_char = hex(sh_last_pc[7:4]);
      7'd41: cur_char = hex(sh_last_pc[3:0]);
      7'd48: cur_char = hex(sh_lcdc[7:4]);
      7'd49: cur_char = hex(sh_lcdc[3:0]);
      7'd56: cur_char = hex(sh_stat[7:4]);
      7'd57: cur_char = hex(sh_stat[3:0]);
      7'd63: cur_char = hex({3'b000, sh_ppu[4]});
      7'd64: cur_char = hex(sh_ppu[3:0]);
      7'd65: cur_char = 8'h0D;
      default: cur_char = 8'h0A;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      halt_s1  <= 1'b0;
      halt_s2  <= 1'b0;
      gb_s1    <= 1'b0;
      gb_s2    <= 1'b0;
      gb_prev  <= 1'b0;
      state    <= S_IDLE;
      char_idx <= '0;
      bit_idx  <= '0;
      clk_cnt  <= '0;
      tx       <= 1'b1;
    end else begin
      halt_s1 <= halt;
      halt_s2 <= halt_s1;
      gb_s1   <= gb_clk;
      gb_s2   <= gb_s1;
      gb_prev <= gb_s2;
      if (state == S_IDLE) begin
        if (halt_s2 && gb_edge) begin
          sh_addr    <= addr;
          sh_data    <= data;
          sh_rd      <= rd;
          sh_wr      <= wr;
          sh_cs      <= cs;
          sh_opcode  <= opcode;
          sh_pc      <= pc;
          sh_last_pc <= last_pc;
          sh_lcdc    <= lcdc;
          sh_stat    <= stat;
          sh_ppu     <= ppu_state;
          state      <= S_SEND;
          char_idx   <= '0;
          bit_idx    <= '0;
          clk_cnt    <= '0;
          tx         <= 1'b0;
        end
      end else if (clk_cnt != CLK_LAST) begin
        clk_cnt <= clk_cnt + CW'(1);
      end else begin
        clk_cnt <= '0;
        if (bit_idx == 4'd9) begin
          bit_idx <= '0;
          if (char_idx == 7'd66) begin
            state    <= S_IDLE;
            char_idx <= '0;
          end else begin
            // Next character's start bit follows the stop bit with no gap.
            char_idx <= char_idx + 7'd1;
            tx       <= 1'b0;
          end
        end else begin
          bit_idx <= bit_idx + 4'd1;
          tx      <= (bit_idx == 4'd8) ? 1'b1 : cur_char[bit_idx[2:0]];
        end
      end
    end
  end
endmodule

// File: tb/tb_gb_debug.sv
// tb/tb_gb_debug.sv - directed bench for gb_debug: UART line decode, latency, gaps, halt drop, reset.
module tb_gb_debug;
  localparam int CPB = 8;
  localparam int NS  = 9 * CPB + CPB / 2 + 1;
  localparam int LW  = 8 * 67;

  logic        clk = 1'b0, reset, gb_clk, halt;
  logic [15:0] addr, pc, last_pc;
  logic [7:0]  data, opcode, lcdc, stat;
  logic        rd, wr, cs;
  logic [4:0]  ppu_state;
  logic        tx;

  int checks = 0;
  int failures = 0;

  gb_debug #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .reset(reset), .gb_clk(gb_clk), .halt(halt), .addr(addr), .data(data),
    .rd(rd), .wr(wr), .cs(cs), .opcode(opcode), .pc(pc), .last_pc(last_pc),
    .lcdc(lcdc), .stat(stat), .ppu_state(ppu_state), .tx(tx)
  );

  always #5 clk = ~clk;
  initial begin
    gb_clk = 1'b0;
    #3;
    forever #100 gb_clk = ~gb_clk;
  end

  typedef struct {
    logic [15:0]   addr;
    logic [7:0]    data;
    logic          rd, wr, cs;
    logic [7:0]    opcode;
    logic [15:0]   pc, last_pc;
    logic [7:0]    lcdc, stat;
    logic [4:0]    ppu;
    logic [LW-1:0] line;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_le(input string name, input int act, input int limit);
    checks++;
    if (act > limit) begin
      failures++;
      $display("FAIL %s: got %0d expected <= %0d", name, act, limit);
    end
  endtask

  task automatic check_line(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got \"%s\" %h expected \"%s\" %h", name,
               act[LW-1:16], act[15:0], exp[LW-1:16], exp[15:0]);
    end
  endtask

  task automatic apply(input vec_t v);
    addr = v.addr; data = v.data; rd = v.rd; wr = v.wr; cs = v.cs;
    opcode = v.opcode; pc = v.pc; last_pc = v.last_pc;
    lcdc = v.lcdc; stat = v.stat; ppu_state = v.ppu;
  endtask

  // Receive one 8N1 character; waited = negedges until start bit seen, start_w = low run length.
  task automatic rx_char(input int budget, output logic [7:0] ch, output bit ok,
                         output int waited, output int start_w);
    logic s[NS];
    bit   got;
    waited = 0; ok = 1'b1; ch = '0; start_w = 0; got = 1'b0;
    while (!got && ok) begin
      @(negedge clk);
      waited++;
      if (tx === 1'b0) got = 1'b1;
      else if (waited >= budget) ok = 1'b0;
    end
    if (!ok) return;
    s[0] = 1'b0;
    for (int i = 1; i < NS; i++) begin
      @(negedge clk);
      s[i] = tx;
    end
    while (start_w < NS && s[start_w] == 1'b0) start_w++;
    for (int b = 0; b < 8; b++) ch[b] = s[CPB * (b + 1) + CPB / 2];
    if (s[NS-1] !== 1'b1) ok = 1'b0;
  endtask

  task automatic rx_line(input int first_budget, input int drop_at, input int pc_at,
                         output logic [LW-1:0] line, output bit ok,
                         output int first_wait, output int start_w);
    logic [7:0] ch;
    bit         cok;
    int         w, sw;
    ok = 1'b1; line = '0; first_wait = -1; start_w = -1;
    for (int c = 0; c < 67; c++) begin
      rx_char((c == 0) ? first_budget : 2 * CPB, ch, cok, w, sw);
      if (!cok) begin
        ok = 1'b0;
        return;
      end
      if (c == 0) begin
        first_wait = w;
        start_w = sw;
      end
      line = {line[LW-9:0], ch};
      if (c == drop_at) halt = 1'b0;
      if (c == pc_at) pc = 16'h1234;
    end
  endtask

  task automatic expect_idle(input string name, input int n);
    bit quiet = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) quiet = 1'b0;
    end
    check(name, 64'(quiet), 64'd1);
  endtask

  logic [LW-1:0] line, exp_pc2;
  logic [7:0]    ch;
  bit            ok;
  int            fw, sw;

  initial begin
    vecs[0] = '{16'h9999, 8'h99, 1'b0, 1'b0, 1'b0, 8'h99, 16'hAAAA, 16'h9999, 8'h00, 8'h41, 5'h1F,
                {"A=9999 D=99 RWC=000 OP=99 PC=AAAA LPC=9999 LCDC=00 STAT=41 PPU=1F", 8'h0D, 8'h0A}};
    vecs[1] = '{16'hFF44, 8'h5A, 1'b1, 1'b0, 1'b1, 8'hCB, 16'h0150, 16'h014F, 8'h91, 8'h85, 5'h05,
                {"A=FF44 D=5A RWC=101 OP=CB PC=0150 LPC=014F LCDC=91 STAT=85 PPU=05", 8'h0D, 8'h0A}};
    vecs[2] = '{16'h0000, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 16'h0000, 16'h0000, 8'h00, 8'h00, 5'h00,
                {"A=0000 D=00 RWC=010 OP=00 PC=0000 LPC=0000 LCDC=00 STAT=00 PPU=00", 8'h0D, 8'h0A}};
    vecs[3] = '{16'hFFFF, 8'hFF, 1'b1, 1'b1, 1'b1, 8'hFF, 16'hFFFF, 16'hFFFF, 8'hFF, 8'hFF, 5'h1F,
                {"A=FFFF D=FF RWC=111 OP=FF PC=FFFF LPC=FFFF LCDC=FF STAT=FF PPU=1F", 8'h0D, 8'h0A}};
    exp_pc2 = {"A=9999 D=99 RWC=000 OP=99 PC=1234 LPC=9999 LCDC=00 STAT=41 PPU=1F", 8'h0D, 8'h0A};

    reset = 1'b1; halt = 1'b0;
    apply(vecs[0]);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_tx", 64'(tx), 64'd1);
    expect_idle("idle_no_halt", 10000);

    // Single lines: halt dropped after the first character, line must still complete.
    for (int v = 0; v < 4; v++) begin
      apply(vecs[v]);
      @(posedge clk);
      #1 halt = 1'b1;
      rx_line(100, 0, -1, line, ok, fw, sw);
      check($sformatf("v%0d_line_ok", v), 64'(ok), 64'd1);
      check_le($sformatf("v%0d_start_latency", v), fw, 23);
      check($sformatf("v%0d_start_bit_width", v), 64'(sw), 64'(CPB));
      check_line($sformatf("v%0d_line", v), line, vecs[v].line);
      expect_idle($sformatf("v%0d_idle_after", v), 200);
    end

    // Three back-to-back lines; pc changes mid line 1, halt drops at char 20 of line 3.
    apply(vecs[0]);
    @(posedge clk);
    #1 halt = 1'b1;
    rx_line(100, -1, 5, line, ok, fw, sw);
    check("l1_ok", 64'(ok), 64'd1);
    check_line("l1_line", line, vecs[0].line);
    rx_line(CPB / 2 + 40, -1, -1, line, ok, fw, sw);
    check("l2_ok", 64'(ok), 64'd1);
    check_le("l2_gap", fw - CPB / 2, 24);
    check_line("l2_line", line, exp_pc2);
    rx_line(CPB / 2 + 40, 20, -1, line, ok, fw, sw);
    check("l3_ok", 64'(ok), 64'd1);
    check_le("l3_gap", fw - CPB / 2, 24);
    check_line("l3_line", line, exp_pc2);
    expect_idle("idle_after_drop", 300);

    // Reset in the middle of character 1's start bit.
    apply(vecs[1]);
    @(posedge clk);
    #1 halt = 1'b1;
    rx_char(100, ch, ok, fw, sw);
    check("rst_first_char", 64'(ch), 64'h41);
    halt = 1'b0;
    repeat (CPB / 2 + 2) @(negedge clk);
    check("pre_reset_low", 64'(tx), 64'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("post_reset_tx", 64'(tx), 64'd1);
    expect_idle("idle_after_reset", 300);
    @(posedge clk);
    #1 halt = 1'b1;
    rx_line(100, 0, -1, line, ok, fw, sw);
    check("rst_relaunch_ok", 64'(ok), 64'd1);
    check_line("rst_relaunch_line", line, vecs[1].line);
    expect_idle("idle_end", 100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
